mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/rr_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int unsigned DEF_N_REQ       = 4;
  localparam int unsigned DEF_ADDR_W      = 20;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 1023;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-controller signals of the arbiter; master = arbiter side.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = DEF_N_REQ,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_rw;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       rdata;
  logic                    mem_start;
  logic                    mem_rw;
  logic [ADDR_W-1:0]       mem_address;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_done;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    busy;
  logic                    err_timeout;

  modport master (
    input  req, req_rw, req_addr, req_wdata, mem_done, mem_rdata,
    output gnt, ack, rdata, mem_start, mem_rw, mem_address, mem_wdata, busy, err_timeout
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata, mem_done, mem_rdata,
    input  gnt, ack, rdata, mem_start, mem_rw, mem_address, mem_wdata, busy, err_timeout
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] pointer,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    winner = '0;
    index  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(pointer) + k) % N_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        index        = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of a single start/done memory controller.
// Define MEM_ARB_TIMEOUT_EN to abort ISSUE after TIMEOUT_CYC cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = DEF_N_REQ,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic           CLOCK_50,
  input logic           reset,
  mem_arbiter_if.master bus
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d, win_q, win_d, pick_idx;
  logic [N_REQ-1:0]  pick_gnt, gnt_q, gnt_d, ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              start_q, start_d, rw_q, rw_d;
  logic              done_hit, timeout_hit;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (bus.req),
    .pointer (ptr_q),
    .winner  (pick_gnt),
    .index   (pick_idx)
  );

  // A done pulse only counts while a command is outstanding.
  assign done_hit = start_q && bus.mem_done;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    start_d = start_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win_d   = pick_idx;
          gnt_d   = pick_gnt;
          start_d = 1'b1;
          rw_d    = bus.req_rw[pick_idx];
          addr_d  = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d = bus.req_wdata[pick_idx*DATA_W +: DATA_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (done_hit) begin
          start_d = 1'b0;
          rdata_d = bus.mem_rdata;
          ack_d   = gnt_q;
          state_d = RELEASE;
        end else if (timeout_hit) begin
          start_d = 1'b0;
          rdata_d = '0;
          ack_d   = gnt_q;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        gnt_d   = '0;
        ptr_d   = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      start_q <= 1'b0;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      start_q <= start_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0] tmr_q;
  logic             err_q;

  // tmr_q counts completed ISSUE cycles; abort at the end of the TIMEOUT_CYC-th one.
  assign timeout_hit = (state_q == ISSUE) && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= (state_q == ISSUE) ? tmr_q + TMR_W'(1) : '0;
      if (timeout_hit && !done_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err_timeout = err_q;
`else
  logic unused_cfg;
  assign unused_cfg      = ^TIMEOUT_CYC;
  assign timeout_hit     = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.gnt         = gnt_q;
  assign bus.ack         = ack_q;
  assign bus.rdata       = rdata_q;
  assign bus.mem_start   = start_q;
  assign bus.mem_rw      = rw_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int TO = 8;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  always #10 CLOCK_50 = ~CLOCK_50;

  mem_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .N_REQ       (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int ptr_m = 0;

  logic [AW-1:0] a_m [N];
  logic [DW-1:0] w_m [N];
  logic [N-1:0]  rw_m;
  int            order [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] rq, input int p);
    logic [1:0] j;
    for (int k = 0; k < N; k++) begin
      j = 2'((p + k) % N);
      if (rq[j]) return int'(j);
    end
    return -1;
  endfunction

  task automatic randomize_fields();
    for (int i = 0; i < N; i++) begin
      a_m[i]  = AW'($urandom);
      w_m[i]  = DW'($urandom);
      rw_m[i] = 1'($urandom);
    end
  endtask

  task automatic load(input logic [N-1:0] rq);
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = a_m[i];
      bus.req_wdata[i*DW +: DW] = w_m[i];
    end
    bus.req_rw = rw_m;
    bus.req    = rq;
  endtask

  // Waits at most 8 cycles for a grant; returns 0 on expiry.
  task automatic wait_gnt(output bit ok);
    int waited = 0;
    do begin
      @(negedge CLOCK_50);
      waited++;
    end while (bus.gnt == '0 && waited < 8);
    ok = (bus.gnt != '0);
    if (!ok) check("gnt_wait", 64'(0), 64'(1));
  endtask

  // Called right after a negedge; ends on the negedge after RELEASE.
  task automatic run_txn(input logic [N-1:0] rq, input int lat, input bit drop,
                         input logic [DW-1:0] rd, output int won);
    int         w;
    int         starts;
    logic [1:0] wi;
    logic [N-1:0] oh;
    bit         ok;
    w   = model_pick(rq, ptr_m);
    wi  = 2'(w);
    oh  = N'(1) << w;
    won = -1;
    load(rq);
    wait_gnt(ok);
    if (!ok) return;
    check("gnt", 64'(bus.gnt), 64'(oh));
    check("mem_address", 64'(bus.mem_address), 64'(a_m[wi]));
    check("mem_rw", 64'(bus.mem_rw), 64'(rw_m[wi]));
    check("mem_wdata", 64'(bus.mem_wdata), 64'(w_m[wi]));
    if (drop) bus.req[wi] = 1'b0;
    starts = bus.mem_start ? 1 : 0;
    for (int k = 0; k < lat; k++) begin
      @(negedge CLOCK_50);
      if (bus.mem_start) starts++;
      check("ack_early", 64'(bus.ack), 64'(0));
      check("addr_hold", 64'(bus.mem_address), 64'(a_m[wi]));
    end
    bus.mem_done  = 1'b1;
    bus.mem_rdata = rd;
    @(negedge CLOCK_50);
    bus.mem_done  = 1'b0;
    bus.mem_rdata = DW'($urandom);
    check("start_cycles", 64'(starts), 64'(lat + 1));
    check("ack", 64'(bus.ack), 64'(oh));
    check("rdata", 64'(bus.rdata), 64'(rd));
    check("start_clr", 64'(bus.mem_start), 64'(0));
    check("wdata_hold", 64'(bus.mem_wdata), 64'(w_m[wi]));
    @(negedge CLOCK_50);
    check("ack_pulse", 64'(bus.ack), 64'(0));
    check("gnt_rel", 64'(bus.gnt), 64'(0));
    ptr_m = (w + 1) % N;
    won   = w;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_gnt"}, 64'(bus.gnt), 64'(0));
    check({tag, "_ack"}, 64'(bus.ack), 64'(0));
    check({tag, "_start"}, 64'(bus.mem_start), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    int         won;
    bit         ok;
    int         exp_order [5] = '{0, 1, 2, 3, 0};
    bus.req       = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    randomize_fields();

    repeat (2) @(negedge CLOCK_50);
    check_idle_state("rst");
    check("rst_rdata", 64'(bus.rdata), 64'(0));
    check("rst_addr", 64'(bus.mem_address), 64'(0));
    check("rst_rw", 64'(bus.mem_rw), 64'(0));
    check("rst_err", 64'(bus.err_timeout), 64'(0));
    reset = 1'b0;

    // Single write, done two cycles after the first ISSUE cycle.
    a_m[0]  = '0;
    w_m[0]  = 16'h1234;
    rw_m[0] = RW_WRITE;
    run_txn(4'b0001, 2, 1'b0, 16'h0000, won);
    check("write_winner", 64'(won), 64'(0));

    // Read from requester 2.
    a_m[2]  = 20'h00001;
    rw_m[2] = RW_READ;
    run_txn(4'b0100, 1, 1'b0, 16'hBEEF, won);
    check("read_winner", 64'(won), 64'(2));

    // Contention from a freshly reset pointer.
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    ptr_m = 0;
    order.delete();
    for (int t = 0; t < 5; t++) begin
      randomize_fields();
      run_txn(4'b1111, int'($urandom_range(0, 3)), 1'b0, DW'($urandom), won);
      order.push_back(won);
    end
    for (int t = 0; t < 5; t++) check("rr_order", 64'(order[t]), 64'(exp_order[t]));

    // Stray done while idle.
    bus.req      = '0;
    bus.mem_done = 1'b1;
    repeat (3) begin
      @(negedge CLOCK_50);
      check_idle_state("stray");
    end
    bus.mem_done = 1'b0;

    // Reset in the middle of ISSUE.
    randomize_fields();
    load(4'b0010);
    wait_gnt(ok);
    @(negedge CLOCK_50);
    check("mid_start", 64'(bus.mem_start), 64'(1));
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check_idle_state("midrst");
    check("midrst_addr", 64'(bus.mem_address), 64'(0));
    ptr_m = 0;
    run_txn(4'b1010, 1, 1'b0, 16'h5A5A, won);
    check("post_rst_winner", 64'(won), 64'(1));

    // Random traffic with idle gaps, stray dones and early request drops.
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] rq;
      if ($urandom_range(0, 3) == 0) begin
        bus.req      = '0;
        bus.mem_done = 1'($urandom);
        @(negedge CLOCK_50);
        check_idle_state("gap");
        bus.mem_done = 1'b0;
      end
      randomize_fields();
      rq = N'($urandom_range(1, 15));
      run_txn(rq, int'($urandom_range(0, 4)), 1'($urandom), DW'($urandom), won);
      check("rand_winner_valid", 64'(won >= 0), 64'(1));
    end

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int         cnt;
      int         w;
      int         guard;
      logic [N-1:0] oh;
      randomize_fields();
      w  = model_pick(4'b1000, ptr_m);
      oh = N'(1) << w;
      load(4'b1000);
      wait_gnt(ok);
      cnt   = bus.mem_start ? 1 : 0;
      guard = 0;
      while (bus.ack == '0 && guard < 30) begin
        @(negedge CLOCK_50);
        guard++;
        if (bus.mem_start) cnt++;
      end
      check("to_cycles", 64'(cnt), 64'(TO));
      check("to_ack", 64'(bus.ack), 64'(oh));
      check("to_rdata", 64'(bus.rdata), 64'(0));
      check("to_err", 64'(bus.err_timeout), 64'(1));
      bus.req = '0;
      @(negedge CLOCK_50);
      check("to_ack_pulse", 64'(bus.ack), 64'(0));
      ptr_m = (w + 1) % N;
      run_txn(4'b0001, 1, 1'b0, 16'hC0DE, won);
      check("to_err_sticky", 64'(bus.err_timeout), 64'(1));
    end
`else
    check("err_tied", 64'(bus.err_timeout), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
